distancias_busca: RTL and testbench

Nearest-target search engine for the occupancy-grid navigation path. On a `novoDado` request it scans the `TamanhoMalha`×`TamanhoMalha` grid outward from the current position, ring by ring, across the enabled quadrants. It reports the coordinates of the first cell marked as a target (2'b11). It sits between the map store, which provides `malha`, and the motion planner, which consumes `destinoX`/`destinoY` when `operacaoFinalizada` is high.

---
 rtl/distancias_busca.sv | 129 ++++++++++++
 tb/tb_distancias_busca.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/distancias_busca.sv
// Nearest-target search over an occupancy grid: scans rings around the latched
// position, one candidate per cycle, across the enabled quadrants.
module distancias_busca #(
   parameter int TamanhoMalha     = 8,
   parameter int tamanhoDistancia = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX,
   input  logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY,
   input  logic                        novoDado,
   input  logic [1:0]                  malha [TamanhoMalha*TamanhoMalha],
   input  logic [3:0]                  enable,
   output logic                        operacaoFinalizada,
   output logic [tamanhoDistancia-1:0] destinoX,
   output logic [tamanhoDistancia-1:0] destinoY
);
   localparam int DW = tamanhoDistancia;
   localparam int CW = tamanhoDistancia + 2;
   localparam logic        [DW-1:0] TU = DW'(TamanhoMalha);
   localparam logic        [DW-1:0] RMAX = DW'(TamanhoMalha - 1);
   localparam logic signed [CW-1:0] TS = CW'(TamanhoMalha);

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   state_t        r_state;
   logic [DW-1:0] r_px, r_py, r_r;
   logic [DW:0]   r_k;
   logic [1:0]    r_q;
   logic [3:0]    r_en;
   logic          r_imm;

   // Quadrant q (0..3) is enabled by enable bit 3-q.
   function automatic logic [1:0] f_first(input logic [3:0] en);
      logic [1:0] q;
      q = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (en[3-i]) q = i[1:0];
      return q;
   endfunction

   logic       w_nq_ok;
   logic [1:0] w_nq;
   always_comb begin
      w_nq_ok = 1'b0;
      w_nq    = r_q;
      for (int i = 3; i >= 0; i--)
         if (i > int'(r_q) && r_en[3-i]) begin
            w_nq_ok = 1'b1;
            w_nq    = i[1:0];
         end
   end

   logic signed [CW-1:0] w_r, w_k, w_dx, w_dy, w_cx, w_cy;
   logic                 w_in, w_hit, w_last_k;
   int                   w_idx;
   always_comb begin
      w_r  = $signed({2'b00, r_r});
      w_k  = $signed({1'b0, r_k});
      w_dx = (w_k <= w_r) ? w_r : (w_r + w_r - w_k);
      w_dy = (w_k <= w_r) ? w_k : w_r;
      // Odd quadrants go left (-X); upper two go back (-Y).
      w_cx = r_q[0] ? ($signed({2'b00, r_px}) - w_dx) : ($signed({2'b00, r_px}) + w_dx);
      w_cy = r_q[1] ? ($signed({2'b00, r_py}) - w_dy) : ($signed({2'b00, r_py}) + w_dy);
      w_in  = !w_cx[CW-1] && !w_cy[CW-1] && (w_cx < TS) && (w_cy < TS);
      w_idx = w_in ? (int'(w_cx) + int'(w_cy) * TamanhoMalha) : 0;
      w_hit = w_in && (malha[w_idx] == 2'b11);
      w_last_k = (r_k == {r_r, 1'b0});
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state            <= IDLE;
         r_px               <= '0;
         r_py               <= '0;
         r_r                <= '0;
         r_k                <= '0;
         r_q                <= '0;
         r_en               <= '0;
         r_imm              <= 1'b0;
         operacaoFinalizada <= 1'b0;
         destinoX           <= '0;
         destinoY           <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: if (novoDado) begin
               r_px               <= posicaoAtualnoEixoX;
               r_py               <= posicaoAtualnoEixoY;
               r_en               <= enable;
               operacaoFinalizada <= 1'b0;
               // Degenerate requests still take one cycle so the flag lands at E0+1.
               r_imm   <= (posicaoAtualnoEixoX >= TU) || (posicaoAtualnoEixoY >= TU) || (enable == 4'b0000);
               r_r     <= DW'(1);
               r_k     <= '0;
               r_q     <= f_first(enable);
               r_state <= SEARCH;
            end
            SEARCH: begin
               if (r_imm) begin
                  destinoX           <= r_px;
                  destinoY           <= r_py;
                  operacaoFinalizada <= 1'b1;
                  r_state            <= DONE;
               end else if (w_hit) begin
                  destinoX           <= w_cx[DW-1:0];
                  destinoY           <= w_cy[DW-1:0];
                  operacaoFinalizada <= 1'b1;
                  r_state            <= DONE;
               end else if (!w_last_k) begin
                  r_k <= r_k + 1'b1;
               end else if (w_nq_ok) begin
                  r_q <= w_nq;
                  r_k <= '0;
               end else if (r_r == RMAX) begin
                  destinoX           <= r_px;
                  destinoY           <= r_py;
                  operacaoFinalizada <= 1'b1;
                  r_state            <= DONE;
               end else begin
                  r_r <= r_r + 1'b1;
                  r_q <= f_first(r_en);
                  r_k <= '0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_distancias_busca.sv
// Scoreboard bench for distancias_busca: a ring-scan model predicts destination
// and latency per request; results are popped and compared when the flag rises.
module tb_distancias_busca;
   localparam int T = 8, W = 8, N = T * T;

   logic         clock = 1'b0, reset = 1'b1, novoDado = 1'b0;
   logic [W-1:0] posX = '0, posY = '0;
   logic [3:0]   enable = 4'b0000;
   logic [1:0]   g [N];
   logic         operacaoFinalizada;
   logic [W-1:0] destinoX, destinoY;

   typedef struct {int x; int y; int lat;} exp_t;
   exp_t sb[$];
   int   nvec = 0, nerr = 0;

   always #5 clock = ~clock;

   distancias_busca #(.TamanhoMalha(T), .tamanhoDistancia(W)) dut (
      .clock(clock), .reset(reset),
      .posicaoAtualnoEixoX(posX), .posicaoAtualnoEixoY(posY),
      .novoDado(novoDado), .malha(g), .enable(enable),
      .operacaoFinalizada(operacaoFinalizada),
      .destinoX(destinoX), .destinoY(destinoY));

   task automatic chk(input string tag, input int got, input int exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_grid();
      for (int i = 0; i < N; i++) g[i] = 2'b00;
   endtask

   // Enumerate the ring scan directly from its definition.
   task automatic model(input int px, input int py, input logic [3:0] en, output exp_t e);
      int n, dx, dy, cx, cy;
      int sx[4] = '{1, -1, 1, -1};
      int sy[4] = '{1, 1, -1, -1};
      e = '{px, py, 1};
      if (px >= T || py >= T || en == 4'b0000) return;
      n = 0;
      for (int r = 1; r < T; r++)
         for (int q = 0; q < 4; q++)
            if (en[3-q])
               for (int k = 0; k <= 2*r; k++) begin
                  n++;
                  dx = (k <= r) ? r : 2*r - k;
                  dy = (k <= r) ? k : r;
                  cx = px + sx[q]*dx;
                  cy = py + sy[q]*dy;
                  if (cx >= 0 && cx < T && cy >= 0 && cy < T && g[cx + cy*T] == 2'b11) begin
                     e = '{cx, cy, n};
                     return;
                  end
               end
      e = '{px, py, n};
   endtask

   // pulse_at > 0 injects a conflicting request that many cycles into the search.
   task automatic run(input string tag, input int px, input int py, input logic [3:0] en, input int pulse_at);
      exp_t m, e;
      int   n;
      bit   seen;
      model(px, py, en, m);
      sb.push_back(m);
      @(negedge clock);
      posX = W'(px); posY = W'(py); enable = en; novoDado = 1'b1;
      @(negedge clock);
      novoDado = 1'b0;
      chk({tag, ".clr"}, int'(operacaoFinalizada), 0);
      n = 0; seen = 1'b0;
      while (!seen && n < 400) begin
         @(negedge clock);
         n++;
         if (n == pulse_at) begin
            novoDado = 1'b1; posX = W'(px ^ 3); enable = 4'b0001;
         end else novoDado = 1'b0;
         if (operacaoFinalizada) seen = 1'b1;
      end
      novoDado = 1'b0;
      e = sb.pop_front();
      chk({tag, ".done"}, int'(seen), 1);
      chk({tag, ".x"}, int'(destinoX), e.x);
      chk({tag, ".y"}, int'(destinoY), e.y);
      chk({tag, ".lat"}, n, e.lat);
      repeat (3) @(negedge clock);
      chk({tag, ".hold"}, int'(destinoX) * 256 + int'(destinoY) + 65536 * int'(operacaoFinalizada),
          e.x * 256 + e.y + 65536);
   endtask

   initial begin
      clr_grid();
      #1 reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst.flag", int'(operacaoFinalizada), 0);
      chk("rst.x", int'(destinoX), 0);
      chk("rst.y", int'(destinoY), 0);
      reset = 1'b1;

      g[2 + 3*T] = 2'b11;
      run("single", 3, 3, 4'b1111, 0);
      run("mask", 3, 3, 4'b1000, 0);

      clr_grid(); g[7 + 7*T] = 2'b11; g[1 + 1*T] = 2'b11;
      run("corner", 0, 0, 4'b1111, 0);

      clr_grid();
      run("empty", 3, 3, 4'b1111, 0);
      run("oob", 9, 2, 4'b1111, 0);
      run("noen", 3, 3, 4'b0000, 0);

      // Abort a long search with reset; its expectation is never pushed.
      @(negedge clock);
      posX = 3; posY = 3; enable = 4'b1111; novoDado = 1'b1;
      @(negedge clock);
      novoDado = 1'b0;
      repeat (10) @(negedge clock);
      reset = 1'b0;
      #1;
      chk("midrst.flag", int'(operacaoFinalizada), 0);
      chk("midrst.x", int'(destinoX), 0);
      chk("midrst.y", int'(destinoY), 0);
      @(negedge clock);
      reset = 1'b1;

      g[5 + 1*T] = 2'b11;
      run("afterrst", 4, 4, 4'b1111, 0);
      clr_grid(); g[1 + 6*T] = 2'b11;
      run("retrig", 4, 4, 4'b1111, 0);

      clr_grid(); g[7 + 7*T] = 2'b11;
      run("ignore", 0, 0, 4'b1111, 5);
      run("ignore2", 6, 1, 4'b0110, 7);

      for (int t = 0; t < 6; t++) begin
         clr_grid();
         g[$urandom_range(N-1)] = 2'b11;
         g[$urandom_range(N-1)] = 2'b11;
         g[$urandom_range(N-1)] = 2'b01;
         run($sformatf("rnd%0d", t), int'($urandom_range(T-1)), int'($urandom_range(T-1)),
             4'($urandom_range(15, 1)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
